reg_file_dump: RTL and testbench
================================

# reg_file_dump

Parametrised multi-port register file that generalises the single-register load blocks into a DEPTH-entry, WIDTH-bit bank. It has one write port, two asynchronous read ports and optional write-to-read bypass. Per-entry dirty tracking and a valid/ready dump engine stream every entry out sequentially to the debug/hex-display path. It sits in the datapath as the general-purpose register bank and feeds the board debug output.

## Interface
- WIDTH, 16, data width of each entry
- DEPTH, 8, number of entries (≥2); AW = $clog2(DEPTH) is derived, not overridable
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return the stored value
- ZERO_R0, 0, 1 = entry 0 is hardwired to zero, writes to it are discarded and never set its dirty bit

- Clk  input  1  clock, all state updates on rising edge
- Reset  input  1  synchronous, active-low; clock Clk
- Load  input  1  write enable
- WrAddr  input  AW  write address
- Din  input  WIDTH  write data
- RdAddrA, RdAddrB  input  AW  read addresses
- DoutA, DoutB  output  WIDTH  read data, combinational
- Dirty  output  DEPTH  per-entry written-since-clear flags
- DirtyClr  input  1  clear all dirty flags
- DumpStart  input  1  begin a dump sequence
- DumpBusy  output  1  dump in progress
- DumpValid  output  1  DumpAddr/DumpData hold a beat
- DumpReady  input  1  sink accepts the beat
- DumpAddr  output  AW  index of the current beat
- DumpData  output  WIDTH  snapshot of the entry at DumpAddr

## Operation
- Reset (Reset==0 at an edge) has priority over everything else:
  - all entries 0, Dirty 0, state IDLE.
  - DumpValid, DumpBusy, DumpAddr and DumpData all 0.
- Write: Load==1 at an edge stores Din into entry WrAddr and sets Dirty[WrAddr].
  - With ZERO_R0=1 and WrAddr==0, nothing is stored and no dirty bit is set.
  - WrAddr ≥ DEPTH (non-power-of-2 DEPTH): the write is discarded.
- Read: DoutX = entry[RdAddrX].
  - With BYPASS=1, Load==1 and WrAddr==RdAddrX, DoutX = Din. This does not apply to a discarded write.
  - ZERO_R0=1 with RdAddrX==0 gives 0.
  - Out-of-range RdAddrX gives 0.
- Dirty: DirtyClr==1 clears all bits. If Load and DirtyClr occur in the same cycle, the written entry's bit ends at 1 (set wins).
- Dump FSM, two states:
  - IDLE: DumpBusy=0, DumpValid=0. DumpStart==1 → DUMP, DumpAddr←0, DumpData←entry[0].
  - DUMP: DumpBusy=1, DumpValid=1.
    - Accept = DumpValid & DumpReady.
    - On accept with DumpAddr<DEPTH-1: DumpAddr+1, and DumpData←entry[DumpAddr+1].
    - On accept with DumpAddr==DEPTH-1: → IDLE, DumpAddr←0.
    - No accept: DumpAddr and DumpData hold, even if that entry is written meanwhile.
  - DumpStart in DUMP is ignored; there is no restart.
- Snapshot semantics: DumpData loads the array value before that edge's write. A write landing on the same edge as the load is not reflected in the dump.
- Dump does not modify Dirty and does not block writes or reads.

## Timing
- Write latency 1 edge. Read is 0-cycle (combinational), bypass 0-cycle.
- DumpStart sampled at edge k → DumpValid=1 in cycle after k.
- Sustained DumpReady=1: one beat per cycle. A full dump takes DEPTH cycles; DumpBusy falls after the edge accepting beat DEPTH-1.
- Back-to-back dumps: a DumpStart held high in the cycle after the return to IDLE starts a new dump. IDLE lasts a minimum of 1 cycle.
- Reset mid-dump: at the next edge return to IDLE, DumpValid=0, with no partial beats afterwards.

## Test plan
- Reset, then Load=1, WrAddr=3, Din=16'hBEEF, RdAddrA=3 in the same cycle → DoutA=BEEF immediately (BYPASS=1). Next cycle with Load=0: DoutA=BEEF and Dirty=8'b0000_1000.
- BYPASS=0 instance, write 3←1234 over prior 0 → DoutA=0 during the write cycle, 1234 after.
- ZERO_R0=1: write 0←FFFF → DoutB(RdAddrB=0)=0 and Dirty[0]=0. Load with DirtyClr in the same cycle on entry 5 → Dirty=8'b0010_0000.
- Fill entries i←16'h1000+i, DumpStart pulse, DumpReady=1 → 8 beats at consecutive cycles, addr 0..7, data 1000..1007. DumpBusy falls after beat 7.
- DumpReady toggling 1,0,0,1…; write entry 2←AAAA while beat 2 is stalled → beat 2 still shows 1002 and beat order is unchanged. A DumpStart during the dump is ignored.
- Reset asserted at beat 4 → next cycle DumpValid=0, DumpAddr=0, all reads 0, Dirty=0.

Source files
------------

// File: rtl/reg_file_dump.sv
// General-purpose register bank: one write port, two combinational read ports,
// per-entry dirty flags and a valid/ready engine that streams every entry out.
module reg_file_dump #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 8,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b0,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic [AW-1:0]    WrAddr,
    input  logic [WIDTH-1:0] Din,
    input  logic [AW-1:0]    RdAddrA,
    input  logic [AW-1:0]    RdAddrB,
    output logic [WIDTH-1:0] DoutA,
    output logic [WIDTH-1:0] DoutB,
    output logic [DEPTH-1:0] Dirty,
    input  logic             DirtyClr,
    input  logic             DumpStart,
    output logic             DumpBusy,
    output logic             DumpValid,
    input  logic             DumpReady,
    output logic [AW-1:0]    DumpAddr,
    output logic [WIDTH-1:0] DumpData
);

    localparam logic [AW:0]   DepthW   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    typedef enum logic {StIdle, StDump} state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic [AW-1:0]    next_addr;
    state_t           state;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DepthW;
    endfunction

    // Out-of-range and hardwired-zero writes are dropped entirely, including bypass.
    assign wr_en     = Load && in_range(WrAddr) && !(ZERO_R0 && WrAddr == '0);
    assign next_addr = DumpAddr + AW'(1);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[WrAddr] <= Din;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            Dirty <= '0;
        end else begin
            if (DirtyClr) begin
                Dirty <= '0;
            end
            if (wr_en) begin
                Dirty[WrAddr] <= 1'b1;
            end
        end
    end

    always_comb begin
        DoutA = '0;
        if (in_range(RdAddrA) && !(ZERO_R0 && RdAddrA == '0)) begin
            if (BYPASS && wr_en && WrAddr == RdAddrA) begin
                DoutA = Din;
            end else begin
                DoutA = mem[RdAddrA];
            end
        end
    end

    always_comb begin
        DoutB = '0;
        if (in_range(RdAddrB) && !(ZERO_R0 && RdAddrB == '0)) begin
            if (BYPASS && wr_en && WrAddr == RdAddrB) begin
                DoutB = Din;
            end else begin
                DoutB = mem[RdAddrB];
            end
        end
    end

    // DumpData samples mem before this edge's write lands, giving snapshot semantics.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= StIdle;
            DumpBusy  <= 1'b0;
            DumpValid <= 1'b0;
            DumpAddr  <= '0;
            DumpData  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (DumpStart) begin
                        state     <= StDump;
                        DumpBusy  <= 1'b1;
                        DumpValid <= 1'b1;
                        DumpAddr  <= '0;
                        DumpData  <= mem[0];
                    end
                end
                StDump: begin
                    if (DumpValid && DumpReady) begin
                        if (DumpAddr == LastAddr) begin
                            state     <= StIdle;
                            DumpBusy  <= 1'b0;
                            DumpValid <= 1'b0;
                            DumpAddr  <= '0;
                        end else begin
                            DumpAddr <= next_addr;
                            DumpData <= mem[next_addr];
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_dump.sv
// Bench for reg_file_dump: three configurations driven in parallel, checked against
// an array/queue reference model, directed scenarios followed by random traffic.
module tb_reg_file_dump;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset, Load, DirtyClr, DumpStart, DumpReady;
    logic [2:0]  WrAddr, RdAddrA, RdAddrB;
    logic [15:0] Din;

    logic [15:0] douta_m, doutb_m, data_m, douta_n, doutb_n, data_n, douta_z, doutb_z, data_z;
    logic [7:0]  dirty_m, dirty_n, dirty_z;
    logic        busy_m, valid_m, busy_n, valid_n, busy_z, valid_z;
    logic [2:0]  addr_m, addr_n, addr_z;

    reg_file_dump #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_m (
        .Clk(Clk), .Reset(Reset), .Load(Load), .WrAddr(WrAddr), .Din(Din),
        .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .DoutA(douta_m), .DoutB(doutb_m),
        .Dirty(dirty_m), .DirtyClr(DirtyClr), .DumpStart(DumpStart), .DumpBusy(busy_m),
        .DumpValid(valid_m), .DumpReady(DumpReady), .DumpAddr(addr_m), .DumpData(data_m)
    );

    reg_file_dump #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut_n (
        .Clk(Clk), .Reset(Reset), .Load(Load), .WrAddr(WrAddr), .Din(Din),
        .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .DoutA(douta_n), .DoutB(doutb_n),
        .Dirty(dirty_n), .DirtyClr(DirtyClr), .DumpStart(DumpStart), .DumpBusy(busy_n),
        .DumpValid(valid_n), .DumpReady(DumpReady), .DumpAddr(addr_n), .DumpData(data_n)
    );

    reg_file_dump #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut_z (
        .Clk(Clk), .Reset(Reset), .Load(Load), .WrAddr(WrAddr), .Din(Din),
        .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .DoutA(douta_z), .DoutB(doutb_z),
        .Dirty(dirty_z), .DirtyClr(DirtyClr), .DumpStart(DumpStart), .DumpBusy(busy_z),
        .DumpValid(valid_z), .DumpReady(DumpReady), .DumpAddr(addr_z), .DumpData(data_z)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: plain arrays for the banks, a beat index for the dump stream.
    logic [15:0] mm [8];
    logic [15:0] mz [8];
    logic [7:0]  dm, dz;
    bit          busy;
    int          idx;
    logic [15:0] ddata, ddata_z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rd_m(input logic [2:0] a, input bit byp);
        if (byp && Load && WrAddr == a) return Din;
        return mm[a];
    endfunction

    function automatic logic [15:0] rd_z(input logic [2:0] a);
        if (a == 3'd0) return 16'h0;
        if (Load && WrAddr == a) return Din;
        return mz[a];
    endfunction

    task automatic model_edge();
        if (!Reset) begin
            for (int i = 0; i < 8; i++) begin
                mm[i] = '0;
                mz[i] = '0;
            end
            dm = '0; dz = '0; busy = 0; idx = 0; ddata = '0; ddata_z = '0;
        end else begin
            if (busy && DumpReady) begin
                if (idx == 7) begin
                    busy = 0;
                    idx  = 0;
                end else begin
                    idx++;
                    ddata   = mm[idx];
                    ddata_z = mz[idx];
                end
            end else if (!busy && DumpStart) begin
                busy = 1; idx = 0; ddata = mm[0]; ddata_z = mz[0];
            end
            if (DirtyClr) begin
                dm = '0;
                dz = '0;
            end
            if (Load) begin
                mm[WrAddr] = Din;
                dm[WrAddr] = 1'b1;
                if (WrAddr != 3'd0) begin
                    mz[WrAddr] = Din;
                    dz[WrAddr] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_comb();
        chk("douta_m", douta_m, rd_m(RdAddrA, 1));
        chk("doutb_m", doutb_m, rd_m(RdAddrB, 1));
        chk("douta_n", douta_n, rd_m(RdAddrA, 0));
        chk("doutb_n", doutb_n, rd_m(RdAddrB, 0));
        chk("douta_z", douta_z, rd_z(RdAddrA));
        chk("doutb_z", doutb_z, rd_z(RdAddrB));
    endtask

    task automatic check_regs();
        chk("dirty_m", dirty_m, dm);
        chk("dirty_n", dirty_n, dm);
        chk("dirty_z", dirty_z, dz);
        chk("valid_m", valid_m, busy);
        chk("busy_m", busy_m, busy);
        chk("addr_m", addr_m, idx);
        chk("valid_n", valid_n, busy);
        chk("valid_z", valid_z, busy);
        chk("addr_z", addr_z, idx);
        if (busy) begin
            chk("data_m", data_m, ddata);
            chk("data_n", data_n, ddata);
            chk("data_z", data_z, ddata_z);
        end
    endtask

    // Called just after an edge with inputs already driven; returns just after the next edge.
    task automatic cycle();
        #2;
        check_comb();
        @(posedge Clk);
        model_edge();
        #1;
        check_regs();
    endtask

    logic [18:0] beats[$];
    bit          wrote;

    initial begin
        Reset = 0; Load = 0; DirtyClr = 0; DumpStart = 0; DumpReady = 0;
        WrAddr = 0; RdAddrA = 0; RdAddrB = 0; Din = 0;
        @(posedge Clk);
        model_edge();
        #1;
        cycle();
        chk("rst_dirty", dirty_m, 8'h00);
        chk("rst_valid", valid_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_addr", addr_m, 3'd0);
        chk("rst_data", data_m, 16'h0);
        Reset = 1;

        // Same-cycle bypass vs. stored value.
        Load = 1; WrAddr = 3; Din = 16'hBEEF; RdAddrA = 3;
        #1;
        chk("bypass_beef", douta_m, 16'hBEEF);
        chk("nobyp_during", douta_n, 16'h0000);
        cycle();
        Load = 0;
        #1;
        chk("after_beef", douta_m, 16'hBEEF);
        chk("nobyp_after", douta_n, 16'hBEEF);
        chk("dirty_beef", dirty_m, 8'h08);
        cycle();

        // Hardwired entry 0 and set-over-clear priority.
        Load = 1; WrAddr = 0; Din = 16'hFFFF; RdAddrB = 0;
        #1;
        chk("zero_r0_read", doutb_z, 16'h0000);
        chk("r0_normal", doutb_m, 16'hFFFF);
        cycle();
        Load = 0;
        #1;
        chk("zero_r0_dirty", dirty_z, 8'h08);
        cycle();
        Load = 1; WrAddr = 5; Din = 16'h5555; DirtyClr = 1;
        cycle();
        Load = 0; DirtyClr = 0;
        #1;
        chk("set_wins_z", dirty_z, 8'h20);
        chk("set_wins_m", dirty_m, 8'h20);
        cycle();

        // Fill and full-rate dump.
        for (int i = 0; i < 8; i++) begin
            Load = 1; WrAddr = 3'(i); Din = 16'h1000 + 16'(i);
            cycle();
        end
        Load = 0; DumpReady = 1; DumpStart = 1;
        cycle();
        DumpStart = 0;
        for (int b = 0; b < 8; b++) begin
            #1;
            chk("beat_valid", valid_m, 1'b1);
            chk("beat_addr", addr_m, b);
            chk("beat_data", data_m, 16'h1000 + b);
            cycle();
        end
        chk("dump_done_busy", busy_m, 1'b0);
        chk("dump_done_valid", valid_m, 1'b0);

        // Stalled dump with write to the held entry and an ignored restart.
        beats.delete();
        wrote = 0;
        DumpStart = 1; DumpReady = 0;
        cycle();
        DumpStart = 0;
        for (int c = 0; c < 40; c++) begin
            DumpReady = (c % 3 == 0);
            Load = 0;
            DumpStart = (c == 5);
            if (valid_m && addr_m == 3'd2 && !DumpReady && !wrote) begin
                Load = 1; WrAddr = 2; Din = 16'hAAAA; wrote = 1;
            end
            if (valid_m && DumpReady) beats.push_back({addr_m, data_m});
            cycle();
            if (beats.size() == 8) break;
        end
        Load = 0; DumpStart = 0; DumpReady = 0;
        chk("stall_beat_count", beats.size(), 8);
        chk("stall_wrote", wrote, 1'b1);
        for (int b = 0; b < 8 && b < beats.size(); b++) begin
            chk("stall_addr", beats[b][18:16], b);
            chk("stall_data", beats[b][15:0], 16'h1000 + b);
        end
        cycle();
        chk("no_restart", busy_m, 1'b0);

        // Reset mid-dump.
        DumpStart = 1; DumpReady = 1;
        cycle();
        DumpStart = 0;
        for (int k = 0; k < 4; k++) cycle();
        chk("at_beat4", addr_m, 3'd4);
        Reset = 0;
        cycle();
        Reset = 1; RdAddrA = 2; RdAddrB = 7;
        #1;
        chk("rst_mid_valid", valid_m, 1'b0);
        chk("rst_mid_addr", addr_m, 3'd0);
        chk("rst_mid_douta", douta_m, 16'h0);
        chk("rst_mid_doutb", doutb_m, 16'h0);
        chk("rst_mid_dirty", dirty_m, 8'h00);
        cycle();
        cycle();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            Reset     = ($urandom_range(0, 99) != 0);
            Load      = 1'($urandom_range(0, 1));
            WrAddr    = 3'($urandom_range(0, 7));
            Din       = 16'($urandom);
            RdAddrA   = 3'($urandom_range(0, 7));
            RdAddrB   = ($urandom_range(0, 3) == 0) ? WrAddr : 3'($urandom_range(0, 7));
            DirtyClr  = ($urandom_range(0, 15) == 0);
            DumpStart = ($urandom_range(0, 7) == 0);
            DumpReady = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
